// File: rtl/flasher_pkg.sv
// Shared types and default geometry for the bound-flasher lamp controller.
package flasher_pkg;

  localparam int LAMP_NUM_DEF = 16;
  localparam int CNT_W_DEF    = 5;
  localparam int KICK_LO_DEF  = 5;
  localparam int KICK_HI_DEF  = 10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP16 = 3'd1,
    S_DN5  = 3'd2,
    S_UP10 = 3'd3,
    S_DN0A = 3'd4,
    S_UP5  = 3'd5,
    S_DN0B = 3'd6
  } main_state_e;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_UP   = 2'b01,
    CNT_DOWN = 2'b10,
    CNT_RSVD = 2'b11
  } count_state_e;

endpackage

// File: rtl/flasher_therm_decode.sv
// Count-to-thermometer decoder: bit i is set iff i < count.
module flasher_therm_decode
  import flasher_pkg::*;
#(
  parameter int LAMP_NUM = LAMP_NUM_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic [CNT_W-1:0]    i_count,
  output logic [LAMP_NUM-1:0] o_therm
);

  // Per-lamp magnitude compare against the count.
  always_comb begin
    o_therm = {LAMP_NUM{1'b0}};
    for (int i = 0; i < LAMP_NUM; i++) begin
      if (i < int'(i_count)) begin
        o_therm[i] = 1'b1;
      end else begin
        o_therm[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/flasher_counter_datapath.sv
// Bound-flasher datapath: main-state register, saturating lamp counter and
// registered thermometer lamp bus, with status fed back to the generator.
module flasher_counter_datapath
  import flasher_pkg::*;
#(
  parameter int LAMP_NUM = LAMP_NUM_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int KICK_LO  = KICK_LO_DEF,
  parameter int KICK_HI  = KICK_HI_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          main_state_n,
  input  logic [CNT_W-1:0]    counter_load,
  input  logic                counter_load_en,
  input  logic [1:0]          count_state,
  output logic [2:0]          main_state,
  output logic [CNT_W-1:0]    counter,
  output logic                kickback_match,
  output logic                at_max,
  output logic                at_zero,
  output logic [LAMP_NUM-1:0] lamp
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LAMP_NUM);
  localparam logic [CNT_W-1:0] CNT_KLO = CNT_W'(KICK_LO);
  localparam logic [CNT_W-1:0] CNT_KHI = CNT_W'(KICK_HI);

  logic [2:0]          r_main_state;
  logic [CNT_W-1:0]    r_counter;
  logic [LAMP_NUM-1:0] r_lamp;
  logic [CNT_W-1:0]    w_counter_next;
  logic [LAMP_NUM-1:0] w_lamp_next;

  // Next count: load (clamped) beats UP/DOWN; counting saturates at both bounds.
  always_comb begin
    w_counter_next = r_counter;
    if (counter_load_en) begin
      if (counter_load > CNT_MAX) begin
        w_counter_next = CNT_MAX;
      end else begin
        w_counter_next = counter_load;
      end
    end else begin
      case (count_state_e'(count_state))
        CNT_UP: begin
          if (r_counter < CNT_MAX) begin
            w_counter_next = r_counter + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            w_counter_next = r_counter;
          end
        end
        CNT_DOWN: begin
          if (r_counter != {CNT_W{1'b0}}) begin
            w_counter_next = r_counter - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            w_counter_next = r_counter;
          end
        end
        default: w_counter_next = r_counter;
      endcase
    end
  end

  // Lamps decode counter_next so the bus lands on the same edge as the count.
  flasher_therm_decode #(
    .LAMP_NUM (LAMP_NUM),
    .CNT_W    (CNT_W)
  ) u_therm (
    .i_count (w_counter_next),
    .o_therm (w_lamp_next)
  );

  // State, count and lamp registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_state <= S_IDLE;
      r_counter    <= {CNT_W{1'b0}};
      r_lamp       <= {LAMP_NUM{1'b0}};
    end else begin
      r_main_state <= main_state_n;
      r_counter    <= w_counter_next;
      r_lamp       <= w_lamp_next;
    end
  end

  // Status flags decoded from registered count; kickback only while counting up.
  always_comb begin
    at_max         = (r_counter == CNT_MAX);
    at_zero        = (r_counter == {CNT_W{1'b0}});
    kickback_match = (count_state == CNT_UP) &&
                     ((r_counter == CNT_KLO) || (r_counter == CNT_KHI));
  end

  assign main_state = r_main_state;
  assign counter    = r_counter;
  assign lamp       = r_lamp;

endmodule

// File: tb/tb_flasher_counter_datapath.sv
// Directed bench for flasher_counter_datapath with a queue-based scoreboard.
module tb_flasher_counter_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  main_state_n;
  logic [4:0]  counter_load;
  logic        counter_load_en;
  logic [1:0]  count_state;
  logic [2:0]  main_state;
  logic [4:0]  counter;
  logic        kickback_match;
  logic        at_max;
  logic        at_zero;
  logic [15:0] lamp;

  typedef struct packed {
    logic [4:0]  cnt;
    logic [15:0] lmp;
    logic [2:0]  ms;
    logic        amax;
    logic        azero;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cnt  = 0;
  logic [2:0] m_ms = 3'd0;

  always #5 clk = ~clk;

  flasher_counter_datapath dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .main_state_n    (main_state_n),
    .counter_load    (counter_load),
    .counter_load_en (counter_load_en),
    .count_state     (count_state),
    .main_state      (main_state),
    .counter         (counter),
    .kickback_match  (kickback_match),
    .at_max          (at_max),
    .at_zero         (at_zero),
    .lamp            (lamp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] therm(input int c);
    logic [16:0] t;
    t = (17'h1 << c) - 17'h1;
    return t[15:0];
  endfunction

  // Drive one cycle of inputs, check kickback combinationally, model the edge
  // into the scoreboard, then pop and compare after the edge.
  task automatic step(input logic rn, input logic [2:0] msn, input logic [4:0] ld,
                      input logic ld_en, input logic [1:0] cs);
    exp_t e;
    exp_t got;
    rst_n = rn; main_state_n = msn; counter_load = ld;
    counter_load_en = ld_en; count_state = cs;
    #1;
    chk("kickback", {31'd0, kickback_match},
        {31'd0, (cs == 2'b01) && (m_cnt == 5 || m_cnt == 10)});
    if (!rn) begin
      m_cnt = 0; m_ms = 3'd0;
    end else begin
      m_ms = msn;
      if (ld_en) m_cnt = (int'(ld) > 16) ? 16 : int'(ld);
      else if (cs == 2'b01 && m_cnt < 16) m_cnt = m_cnt + 1;
      else if (cs == 2'b10 && m_cnt > 0) m_cnt = m_cnt - 1;
    end
    e.cnt = 5'(m_cnt); e.lmp = therm(m_cnt); e.ms = m_ms;
    e.amax = (m_cnt == 16); e.azero = (m_cnt == 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk("counter",    {27'd0, counter},    {27'd0, got.cnt});
      chk("lamp",       {16'd0, lamp},       {16'd0, got.lmp});
      chk("main_state", {29'd0, main_state}, {29'd0, got.ms});
      chk("at_max",     {31'd0, at_max},     {31'd0, got.amax});
      chk("at_zero",    {31'd0, at_zero},    {31'd0, got.azero});
    end
  endtask

  initial begin
    // Reset and reset-state values
    step(1'b0, 3'd0, 5'd0, 1'b0, 2'b00);
    step(1'b0, 3'd0, 5'd0, 1'b0, 2'b01);
    chk("rst_counter", {27'd0, counter}, 32'd0);
    chk("rst_lamp", {16'd0, lamp}, 32'd0);
    chk("rst_at_zero", {31'd0, at_zero}, 32'd1);
    chk("rst_at_max", {31'd0, at_max}, 32'd0);

    // 1. UP for 20 cycles, saturating at 16
    for (int i = 0; i < 20; i++) step(1'b1, 3'd1, 5'd0, 1'b0, 2'b01);
    chk("sat_counter", {27'd0, counter}, 32'd16);
    chk("sat_lamp", {16'd0, lamp}, 32'h0000FFFF);

    // 2. From 3, DOWN for 6 cycles, no underflow
    step(1'b1, 3'd2, 5'd3, 1'b1, 2'b00);
    for (int i = 0; i < 6; i++) step(1'b1, 3'd2, 5'd0, 1'b0, 2'b10);
    chk("floor_counter", {27'd0, counter}, 32'd0);

    // 3. UP from 0 through both kickback points, reserved code holds
    for (int i = 0; i < 12; i++) step(1'b1, 3'd3, 5'd0, 1'b0, 2'b01);
    step(1'b1, 3'd3, 5'd0, 1'b0, 2'b11);
    step(1'b1, 3'd4, 5'd5, 1'b1, 2'b00);
    step(1'b1, 3'd4, 5'd0, 1'b0, 2'b10);
    step(1'b1, 3'd4, 5'd5, 1'b1, 2'b00);
    step(1'b1, 3'd4, 5'd0, 1'b0, 2'b00);

    // 4. Load beats count; over-range load clamps
    step(1'b1, 3'd5, 5'd7, 1'b1, 2'b00);
    step(1'b1, 3'd5, 5'd4, 1'b1, 2'b01);
    chk("load_lamp", {16'd0, lamp}, 32'h0000000F);
    step(1'b1, 3'd5, 5'd25, 1'b1, 2'b10);
    chk("clamp_counter", {27'd0, counter}, 32'd16);

    // 5. main_state follows with one-cycle latency, illegal code passes through
    step(1'b1, 3'd1, 5'd0, 1'b0, 2'b00);
    step(1'b1, 3'd2, 5'd0, 1'b0, 2'b00);
    step(1'b1, 3'd3, 5'd0, 1'b0, 2'b00);
    step(1'b1, 3'd7, 5'd0, 1'b0, 2'b00);

    // 6. Reset mid-count while UP, then resume
    step(1'b1, 3'd6, 5'd12, 1'b1, 2'b00);
    step(1'b0, 3'd6, 5'd0, 1'b0, 2'b01);
    chk("midrst_main_state", {29'd0, main_state}, 32'd0);
    step(1'b1, 3'd6, 5'd0, 1'b0, 2'b01);
    step(1'b1, 3'd6, 5'd0, 1'b0, 2'b01);
    chk("resume_counter", {27'd0, counter}, 32'd2);

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flasher_counter_datapath.md
Name: flasher_counter_datapath

Overview:
Sequential datapath for the bound-flasher lamp controller: the consumer of the next-state generator's outputs (main_state_n, counter_load, counter_load_en, count_state).
- Registers the main state.
- Runs the lamp counter (load, count up or down, saturating at the bounds).
- Drives the 16-lamp thermometer bus.
- Returns main_state, counter and kickback_match to the generator, closing the control loop.

Parameters:
LAMP_NUM, 16, number of lamps; counter range is 0..LAMP_NUM.
CNT_W, 5, counter width; must satisfy 2^CNT_W > LAMP_NUM.
KICK_LO, 5, lower kickback point (lamp count).
KICK_HI, 10, upper kickback point (lamp count).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
main_state_n  in  3  next main state from the generator.
counter_load  in  CNT_W  value loaded into the counter when counter_load_en=1.
counter_load_en  in  1  counter load strobe.
count_state  in  2  counter mode: 00 HOLD, 01 UP, 10 DOWN, 11 reserved (treated as HOLD).
main_state  out  3  registered main state, fed back to the generator.
counter  out  CNT_W  registered lamp count, fed back to the generator.
kickback_match  out  1  combinational from registers: count_state==UP and counter is KICK_LO or KICK_HI.
at_max  out  1  combinational: counter==LAMP_NUM.
at_zero  out  1  combinational: counter==0.
lamp  out  LAMP_NUM  registered thermometer: lamp[i]=1 iff i < counter.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values: main_state=S_IDLE (3'd0), counter=0, lamp=0. Derived outputs at reset: kickback_match=0, at_zero=1, at_max=0.
- Reset asserted mid-count overrides everything on that edge; no partial update.
- Main state register: main_state <= main_state_n every cycle, no qualification. Latency is 1 clock.
- Counter update priority per edge:
  1. reset;
  2. counter_load_en=1: counter <= min(counter_load, LAMP_NUM). Values above LAMP_NUM clamp to LAMP_NUM.
  3. UP: counter <= counter+1 if counter<LAMP_NUM, else hold (saturate, no wrap).
  4. DOWN: counter <= counter-1 if counter>0, else hold (no underflow to 31).
  5. HOLD or reserved code: hold.
- Load and count in the same cycle: load wins, and count_state is ignored for that edge.
- Lamp bus timing: lamp is registered from counter_next, so lamp and counter change on the same edge. lamp is always the thermometer of counter, never stale by a cycle.
- kickback_match:
  - Combinational from counter and count_state only; no input-to-output path from the load inputs.
  - Asserts in the cycle counter equals KICK_LO or KICK_HI while UP. It is 0 in DOWN, HOLD and reserved.
  - The generator owns the reaction (load KICK_LO-1 and switch to DOWN).
- Illegal main_state_n codes (7) are registered unchanged; the generator owns legality.
- No X propagation: all registers have reset values, and all case statements carry a default.

Decomposition:
- Package flasher_pkg: main state enum (S_IDLE=0, S_UP16=1, S_DN5=2, S_UP10=3, S_DN0A=4, S_UP5=5, S_DN0B=6), count_state enum (CNT_HOLD, CNT_UP, CNT_DOWN, CNT_RSVD), defaults for LAMP_NUM/KICK_LO/KICK_HI.
- Sub-module: one, flasher_therm_decode, a pure combinational count-to-thermometer decoder of width LAMP_NUM, instantiated on counter_next.

Test Plan:
1. Reset then UP for 20 cycles:
   - counter steps 0..16 and stays 16 for the final 4 cycles.
   - lamp reaches 16'hFFFF.
   - at_max=1 from cycle 16.
2. From counter=3, DOWN for 6 cycles:
   - counter goes 2,1,0,0,0,0.
   - lamp reaches 0.
   - at_zero=1, with no wrap to 31.
3. UP from 0:
   - kickback_match=1 exactly when counter=5 and again when counter=10, 0 otherwise.
   - With count_state=DOWN at counter=5, kickback_match=0.
4. counter=7 with counter_load_en=1, counter_load=4, count_state=UP on the same edge:
   - Next counter=4, lamp=16'h000F.
   - Load of 5'd25 yields counter=16.
5. main_state_n driven 1,2,3 on consecutive edges: main_state follows with 1-cycle latency.
6. rst_n low for one edge while counter=12 and UP:
   - Next cycle: counter=0, lamp=0, main_state=0.
   - Counting resumes the cycle after rst_n returns high.
